// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline stall/forward controller.
// Optional statistics outputs are enabled with HAZARD_STATS_EN.
package hazard_pkg;

  localparam int REG_AW = 5;
  localparam int T_W    = 4;

  localparam logic [T_W-1:0] TUSE_NONE = 4'd7;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_E   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;
  localparam logic [1:0] FWD_W   = 2'd3;

  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] a3;
    logic [T_W-1:0]    tnew;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
  } slot_t;

  localparam slot_t BUBBLE = '0;

  function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] x);
    return (x == '0) ? '0 : x - T_W'(1);
  endfunction

endpackage

// File: rtl/hazard_slot.sv
// One in-flight pipeline slot: loads the upstream instruction with its
// Tnew counted down by one, or a bubble when asked to.
module hazard_slot
  import hazard_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  bubble,
  input  slot_t d,
  output slot_t q
);

  slot_t nxt;

  always_comb begin
    nxt      = d;
    nxt.tnew = sat_dec(d.tnew);
    if (bubble) nxt = BUBBLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) q <= BUBBLE;
    else        q <= nxt;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/forward controller for the 5-stage pipeline: tracks writers in E/M/W
// and derives stall plus forwarding selects. Define HAZARD_STATS_EN for stall statistics.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] D_rs,
  input  logic [REG_AW-1:0] D_rt,
  input  logic [T_W-1:0]    D_rs_Tuse,
  input  logic [T_W-1:0]    D_rt_Tuse,
  input  logic [T_W-1:0]    D_Tnew,
  input  logic              D_GRF_write,
  input  logic [REG_AW-1:0] D_A3,
  output logic              stall,
  output logic [1:0]        D_rs_fwd,
  output logic [1:0]        D_rt_fwd,
  output logic [1:0]        E_rs_fwd,
  output logic [1:0]        E_rt_fwd,
  output logic [1:0]        M_rt_fwd
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [2:0]        bubble_run
`endif
);

  slot_t e_d, e_q, m_q, w_d, w_q;

  always_comb begin
    e_d      = BUBBLE;
    e_d.we   = D_GRF_write;
    e_d.a3   = D_A3;
    e_d.tnew = D_Tnew;
    e_d.rs   = D_rs;
    e_d.rt   = D_rt;
  end

  // W never forwards onward by operand, so its rs/rt are not carried.
  always_comb begin
    w_d    = m_q;
    w_d.rs = '0;
    w_d.rt = '0;
  end

  hazard_slot u_slot_e (.clk(clk), .reset(reset), .bubble(stall), .d(e_d), .q(e_q));
  hazard_slot u_slot_m (.clk(clk), .reset(reset), .bubble(1'b0),  .d(e_q), .q(m_q));
  hazard_slot u_slot_w (.clk(clk), .reset(reset), .bubble(1'b0),  .d(w_d), .q(w_q));

  function automatic logic live_match(input slot_t s, input logic [REG_AW-1:0] r);
    return s.we && (s.a3 != '0) && (s.a3 == r);
  endfunction

  function automatic logic hit(input slot_t s, input logic [REG_AW-1:0] r,
                               input logic [T_W-1:0] tuse);
    return live_match(s, r) && (tuse < s.tnew);
  endfunction

  // Nearest matching writer wins; if it is not ready yet it blocks older stages.
  function automatic logic [1:0] fwd_pick(input slot_t s0, input logic [1:0] c0,
                                          input slot_t s1, input logic [1:0] c1,
                                          input slot_t s2, input logic [1:0] c2,
                                          input logic [REG_AW-1:0] r);
    if (live_match(s0, r)) return (s0.tnew == '0) ? c0 : FWD_REG;
    if (live_match(s1, r)) return (s1.tnew == '0) ? c1 : FWD_REG;
    if (live_match(s2, r)) return (s2.tnew == '0) ? c2 : FWD_REG;
    return FWD_REG;
  endfunction

  always_comb begin
    stall    = hit(e_q, D_rs, D_rs_Tuse) | hit(m_q, D_rs, D_rs_Tuse) |
               hit(e_q, D_rt, D_rt_Tuse) | hit(m_q, D_rt, D_rt_Tuse);
    D_rs_fwd = fwd_pick(e_q, FWD_E, m_q, FWD_M, w_q, FWD_W, D_rs);
    D_rt_fwd = fwd_pick(e_q, FWD_E, m_q, FWD_M, w_q, FWD_W, D_rt);
    E_rs_fwd = fwd_pick(m_q, FWD_M, w_q, FWD_W, BUBBLE, FWD_REG, e_q.rs);
    E_rt_fwd = fwd_pick(m_q, FWD_M, w_q, FWD_W, BUBBLE, FWD_REG, e_q.rt);
    M_rt_fwd = live_match(w_q, m_q.rt) ? FWD_W : FWD_REG;
  end

  logic unused_slot_bits;
  assign unused_slot_bits = ^{m_q.rs, w_q.rs, w_q.rt};

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt  <= '0;
      bubble_run <= '0;
    end else begin
      if (stall) stall_cnt <= stall_cnt + 32'd1;
      if (!stall)                  bubble_run <= '0;
      else if (bubble_run != 3'd7) bubble_run <= bubble_run + 3'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios followed by
// random instruction streams, checked against a cycle-history reference model.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] D_rs, D_rt, D_A3;
  logic [3:0] D_rs_Tuse, D_rt_Tuse, D_Tnew;
  logic       D_GRF_write;
  logic       stall;
  logic [1:0] D_rs_fwd, D_rt_fwd, E_rs_fwd, E_rt_fwd, M_rt_fwd;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt;
  logic [2:0]  bubble_run;
`endif

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_rs_Tuse(D_rs_Tuse), .D_rt_Tuse(D_rt_Tuse),
    .D_Tnew(D_Tnew), .D_GRF_write(D_GRF_write), .D_A3(D_A3),
    .stall(stall), .D_rs_fwd(D_rs_fwd), .D_rt_fwd(D_rt_fwd),
    .E_rs_fwd(E_rs_fwd), .E_rt_fwd(E_rt_fwd), .M_rt_fwd(M_rt_fwd)
`ifdef HAZARD_STATS_EN
    , .stall_cnt(stall_cnt), .bubble_run(bubble_run)
`endif
  );

  // Each record is the instruction seen in D at that cycle; it sits k stages
  // downstream k cycles later with max(Tnew-k,0) cycles still to go.
  typedef struct {
    bit         issued;
    bit         we;
    logic [4:0] a3;
    int         tnew;
    logic [4:0] rs;
    logic [4:0] rt;
  } ins_t;

  ins_t hist[1024];
  int   now = 0;
  int   last_rst = -1;
  int   vectors = 0;
  int   miscompares = 0;
  bit         exp_stall;
  logic [1:0] exp_drs, exp_drt, exp_ers, exp_ert, exp_mrt;
  int   cnt_m = 0;
  int   run_m = 0;

  function automatic bit present(input int k, output ins_t x);
    int c = now - k;
    x = '{default: 0};
    if (c < 0 || c <= last_rst) return 0;
    if (!hist[c].issued) return 0;
    x = hist[c];
    return 1;
  endfunction

  function automatic int remaining(input ins_t x, input int k);
    return (x.tnew > k) ? x.tnew - k : 0;
  endfunction

  function automatic bit writes(input ins_t x, input logic [4:0] r);
    return x.we && (x.a3 != 5'd0) && (x.a3 == r);
  endfunction

  function automatic logic [1:0] exp_fwd(input int kfirst, input logic [4:0] r);
    ins_t x;
    for (int k = kfirst; k <= 3; k++)
      if (present(k, x) && writes(x, r))
        return (remaining(x, k) == 0) ? 2'(k) : 2'd0;
    return 2'd0;
  endfunction

  function automatic bit exp_hazard();
    ins_t x;
    for (int k = 1; k <= 2; k++)
      if (present(k, x)) begin
        if (writes(x, D_rs) && int'(D_rs_Tuse) < remaining(x, k)) return 1;
        if (writes(x, D_rt) && int'(D_rt_Tuse) < remaining(x, k)) return 1;
      end
    return 0;
  endfunction

  task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s cycle=%0d observed=%0d expected=%0d", tag, now, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [3:0] rs_tuse, input logic [3:0] rt_tuse,
                               input logic [3:0] tnew, input logic we, input logic [4:0] a3);
    reset = rst; D_rs = rs; D_rt = rt; D_rs_Tuse = rs_tuse; D_rt_Tuse = rt_tuse;
    D_Tnew = tnew; D_GRF_write = we; D_A3 = a3;
  endtask

  task automatic checkOutput();
    ins_t xe, xm, xw;
    logic [4:0] ers, ert, mrt;
    ers = present(1, xe) ? xe.rs : 5'd0;
    ert = present(1, xe) ? xe.rt : 5'd0;
    mrt = present(2, xm) ? xm.rt : 5'd0;
    exp_stall = exp_hazard();
    exp_drs = exp_fwd(1, D_rs);
    exp_drt = exp_fwd(1, D_rt);
    exp_ers = exp_fwd(2, ers);
    exp_ert = exp_fwd(2, ert);
    exp_mrt = (present(3, xw) && writes(xw, mrt)) ? 2'd3 : 2'd0;
    checkOne("stall",    32'(stall),    32'(exp_stall));
    checkOne("D_rs_fwd", 32'(D_rs_fwd), 32'(exp_drs));
    checkOne("D_rt_fwd", 32'(D_rt_fwd), 32'(exp_drt));
    checkOne("E_rs_fwd", 32'(E_rs_fwd), 32'(exp_ers));
    checkOne("E_rt_fwd", 32'(E_rt_fwd), 32'(exp_ert));
    checkOne("M_rt_fwd", 32'(M_rt_fwd), 32'(exp_mrt));
`ifdef HAZARD_STATS_EN
    checkOne("stall_cnt",  stall_cnt,        32'(cnt_m));
    checkOne("bubble_run", 32'(bubble_run),  32'(run_m));
`endif
  endtask

  task automatic drive(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [3:0] rs_tuse, input logic [3:0] rt_tuse,
                       input logic [3:0] tnew, input logic we, input logic [4:0] a3);
    applyStimulus(rst, rs, rt, rs_tuse, rt_tuse, tnew, we, a3);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic advance();
    hist[now] = '{issued: (reset && !exp_stall), we: D_GRF_write, a3: D_A3,
                  tnew: int'(D_Tnew), rs: D_rs, rt: D_rt};
    if (!reset) begin
      last_rst = now;
      cnt_m = 0;
      run_m = 0;
    end else if (exp_stall) begin
      cnt_m++;
      if (run_m < 7) run_m++;
    end else begin
      run_m = 0;
    end
    @(posedge clk);
    #1;
    now++;
  endtask

  task automatic nop();
    drive(1'b1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 4'd0, 1'b0, 5'd0);
    advance();
  endtask

  logic [4:0] regs[5] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd31};
  logic [3:0] tuses[4] = '{4'd0, 4'd1, 4'd2, 4'd7};

  initial begin
    applyStimulus(1'b0, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 4'd0, 1'b0, 5'd0);
    repeat (2) @(posedge clk);
    #1;

    // lw $8 then add $9,$8,$8: one stall, then W forwarding into E
    drive(1'b1, 5'd29, 5'd0, 4'd1, TUSE_NONE, 4'd3, 1'b1, 5'd8);  advance();
    drive(1'b1, 5'd8, 5'd8, 4'd1, 4'd1, 4'd2, 1'b1, 5'd9);
    checkOne("c1_stall", 32'(stall), 32'd1);                       advance();
    drive(1'b1, 5'd8, 5'd8, 4'd1, 4'd1, 4'd2, 1'b1, 5'd9);
    checkOne("c1_release", 32'(stall), 32'd0);                     advance();
    drive(1'b1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 4'd0, 1'b0, 5'd0);
    checkOne("c1_E_rs_W", 32'(E_rs_fwd), 32'd3);
    checkOne("c1_E_rt_W", 32'(E_rt_fwd), 32'd3);                   advance();

    // add $8 then beq $8,$0: one stall, then M forwarding into D
    drive(1'b1, 5'd1, 5'd2, 4'd1, 4'd1, 4'd2, 1'b1, 5'd8);         advance();
    drive(1'b1, 5'd8, 5'd0, 4'd0, 4'd0, 4'd0, 1'b0, 5'd0);
    checkOne("c2_stall", 32'(stall), 32'd1);                       advance();
    drive(1'b1, 5'd8, 5'd0, 4'd0, 4'd0, 4'd0, 1'b0, 5'd0);
    checkOne("c2_release", 32'(stall), 32'd0);
    checkOne("c2_D_rs_M", 32'(D_rs_fwd), 32'd2);                   advance();

    // jal then jr $31: immediate E forwarding, no stall
    drive(1'b1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 4'd1, 1'b1, 5'd31); advance();
    drive(1'b1, 5'd31, 5'd0, 4'd0, TUSE_NONE, 4'd0, 1'b0, 5'd0);
    checkOne("c3_stall", 32'(stall), 32'd0);
    checkOne("c3_D_rs_E", 32'(D_rs_fwd), 32'd1);                   advance();

    // lw $5 then sw $5,0($6): no stall, W forwarding into M store data
    drive(1'b1, 5'd29, 5'd0, 4'd1, TUSE_NONE, 4'd3, 1'b1, 5'd5);   advance();
    drive(1'b1, 5'd6, 5'd5, 4'd1, 4'd2, 4'd0, 1'b0, 5'd0);
    checkOne("c4_stall", 32'(stall), 32'd0);                       advance();
    drive(1'b1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 4'd0, 1'b0, 5'd0);
    checkOne("c4_E_rt_blocked", 32'(E_rt_fwd), 32'd0);             advance();
    drive(1'b1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 4'd0, 1'b0, 5'd0);
    checkOne("c4_M_rt_W", 32'(M_rt_fwd), 32'd3);                   advance();

    // writes to $0 are never forwarded and never stall
    drive(1'b1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 4'd2, 1'b1, 5'd0); advance();
    drive(1'b1, 5'd0, 5'd0, 4'd1, 4'd1, 4'd2, 1'b1, 5'd9);
    checkOne("c5_stall", 32'(stall), 32'd0);
    checkOne("c5_D_rs", 32'(D_rs_fwd), 32'd0);
    checkOne("c5_D_rt", 32'(D_rt_fwd), 32'd0);                     advance();
    nop(); nop(); nop();

    // reset during a load-use stall drops the stall and empties the slots
    drive(1'b1, 5'd29, 5'd0, 4'd1, TUSE_NONE, 4'd3, 1'b1, 5'd8);   advance();
    drive(1'b0, 5'd8, 5'd8, 4'd1, 4'd1, 4'd2, 1'b1, 5'd9);
    checkOne("c6_stall_before", 32'(stall), 32'd1);                advance();
    drive(1'b1, 5'd8, 5'd8, 4'd1, 4'd1, 4'd2, 1'b1, 5'd9);
    checkOne("c6_stall_after", 32'(stall), 32'd0);
    checkOne("c6_E_rs", 32'(E_rs_fwd), 32'd0);
    checkOne("c6_M_rt", 32'(M_rt_fwd), 32'd0);
`ifdef HAZARD_STATS_EN
    checkOne("c6_stall_cnt", stall_cnt, 32'd0);
`endif
    advance();

    // random instruction stream over a small register set to provoke hazards
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 39) != 0),
            regs[$urandom_range(0, 4)], regs[$urandom_range(0, 4)],
            tuses[$urandom_range(0, 3)], tuses[$urandom_range(0, 3)],
            4'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
            regs[$urandom_range(0, 4)]);
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
